// File: rtl/arbiter_pkg.sv
// Shared encodings for the two-requester burst arbiter: FSM states,
// mux select values and the channel data width.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } arb_state_e;

  localparam logic SEL_A  = 1'b0;
  localparam logic SEL_B  = 1'b1;
  localparam int   DATA_W = 16;

endpackage

// File: rtl/mux2x1_16b.sv
// 16-bit two-input multiplexer: S = A when Sel = 0, B when Sel = 1.
module MUX2x1_16B (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Sel,
  output logic [15:0] S
);

  assign S = Sel ? B : A;

endmodule

// File: rtl/bus_arbiter_2x16.sv
// Round-robin burst arbiter sharing one registered 16-bit valid/ready channel
// between requesters A and B.
module bus_arbiter_2x16
  import arbiter_pkg::*;
#(
  parameter  int BURST_MAX = 4,
  localparam int CNT_W     = $clog2(BURST_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              A_valid,
  input  logic [15:0]       A_data,
  input  logic              A_last,
  output logic              A_ready,
  input  logic              B_valid,
  input  logic [15:0]       B_data,
  input  logic              B_last,
  output logic              B_ready,
  output logic              S_valid,
  output logic [15:0]       S_data,
  input  logic              S_ready,
  output logic              Sel,
  output logic [1:0]        Grant,
  output logic [1:0]        dbg_state_o,
  output logic [CNT_W-1:0]  dbg_cnt_o
);

  localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(BURST_MAX);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              prio_q, prio_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [DATA_W-1:0] mux_s;
  logic              out_free, xfer, owner_last, rel;

  // Handshake: x_ready = (state == OWN_x) & (~S_valid | S_ready); a word moves
  // on x_valid & x_ready, and leaves on S_valid & S_ready.
  assign out_free = ~s_valid_q | S_ready;
  assign A_ready  = (state_q == OWN_A) & out_free;
  assign B_ready  = (state_q == OWN_B) & out_free;

  assign Sel         = (state_q == OWN_B) ? SEL_B : SEL_A;
  assign Grant       = {state_q == OWN_B, state_q == OWN_A};
  assign S_valid     = s_valid_q;
  assign S_data      = s_data_q;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

  MUX2x1_16B u_mux (
    .A   (A_data),
    .B   (B_data),
    .Sel (Sel),
    .S   (mux_s)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prio_d     = prio_q;
    s_valid_d  = s_valid_q;
    s_data_d   = s_data_q;
    owner_last = (state_q == OWN_B) ? B_last : A_last;
    xfer       = (A_valid & A_ready) | (B_valid & B_ready);
    cnt_inc    = cnt_q + CNT_W'(1);
    rel        = xfer & (owner_last | (cnt_inc == BURST_MAX_C));

    if (xfer) begin
      s_data_d  = mux_s;
      s_valid_d = 1'b1;
      cnt_d     = cnt_inc;
    end else if (S_ready) begin
      s_valid_d = 1'b0;
    end

    // A burst closed by 'last' means the owner is done; only a count-forced
    // release re-grants the same requester when the other one is idle.
    case (state_q)
      IDLE: begin
        if (A_valid && (!B_valid || prio_q == SEL_A)) state_d = OWN_A;
        else if (B_valid)                             state_d = OWN_B;
      end
      OWN_A: begin
        if (rel) begin
          cnt_d  = '0;
          prio_d = SEL_B;
          if (B_valid)                 state_d = OWN_B;
          else if (A_valid && !A_last) state_d = OWN_A;
          else                         state_d = IDLE;
        end
      end
      OWN_B: begin
        if (rel) begin
          cnt_d  = '0;
          prio_d = SEL_A;
          if (A_valid)                 state_d = OWN_A;
          else if (B_valid && !B_last) state_d = OWN_B;
          else                         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prio_q    <= SEL_A;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prio_q    <= prio_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2x16.sv
// Directed bench for bus_arbiter_2x16 (BURST_MAX = 4): reset, contention,
// early last, back-pressure, reset mid-burst and a single-requester burst.
module tb_bus_arbiter_2x16;

  logic        clk = 1'b0;
  logic        rst;
  logic        A_valid, A_last, A_ready;
  logic [15:0] A_data;
  logic        B_valid, B_last, B_ready;
  logic [15:0] B_data;
  logic        S_valid, S_ready, Sel;
  logic [15:0] S_data;
  logic [1:0]  Grant, dbg_state;
  logic [2:0]  dbg_cnt;

  int tests  = 0;
  int failed = 0;
  int a_idx  = 0;
  int b_idx  = 0;
  bit auto_data = 1'b1;

  logic [15:0] exp_w [12] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                              16'hB000, 16'hB001, 16'hB002, 16'hB003,
                              16'hA004, 16'hA005, 16'hA006, 16'hA007};
  logic [1:0]  exp_g [12] = '{2'b01, 2'b01, 2'b01, 2'b10,
                              2'b10, 2'b10, 2'b10, 2'b01,
                              2'b01, 2'b01, 2'b01, 2'b10};

  bus_arbiter_2x16 #(.BURST_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .A_valid     (A_valid),
    .A_data      (A_data),
    .A_last      (A_last),
    .A_ready     (A_ready),
    .B_valid     (B_valid),
    .B_data      (B_data),
    .B_last      (B_last),
    .B_ready     (B_ready),
    .S_valid     (S_valid),
    .S_data      (S_data),
    .S_ready     (S_ready),
    .Sel         (Sel),
    .Grant       (Grant),
    .dbg_state_o (dbg_state),
    .dbg_cnt_o   (dbg_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample accepts before the edge, then advance the streaming data.
  task automatic tick();
    logic acc_a, acc_b;
    #1;
    acc_a = A_valid & A_ready & ~rst;
    acc_b = B_valid & B_ready & ~rst;
    @(posedge clk);
    #1;
    if (auto_data) begin
      if (acc_a) begin a_idx++; A_data = 16'hA000 + 16'(a_idx); end
      if (acc_b) begin b_idx++; B_data = 16'hB000 + 16'(b_idx); end
    end
  endtask

  initial begin
    rst = 1'b1; S_ready = 1'b1;
    A_valid = 1'b1; A_last = 1'b0; A_data = 16'hA000;
    B_valid = 1'b1; B_last = 1'b0; B_data = 16'hB000;

    tick(); tick();
    chk("rst_grant",   Grant,     2'b00);
    chk("rst_sel",     Sel,       1'b0);
    chk("rst_a_ready", A_ready,   1'b0);
    chk("rst_b_ready", B_ready,   1'b0);
    chk("rst_s_valid", S_valid,   1'b0);
    chk("rst_s_data",  S_data,    16'h0000);
    chk("rst_cnt",     dbg_cnt,   3'd0);
    chk("rst_state",   dbg_state, 2'b00);

    rst = 1'b0;
    tick();
    chk("first_grant_a", Grant,   2'b01);
    chk("first_s_valid", S_valid, 1'b0);
    chk("first_a_ready", A_ready, 1'b1);
    chk("first_b_ready", B_ready, 1'b0);

    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("cont_data_%0d", i),  S_data,  exp_w[i]);
      chk($sformatf("cont_valid_%0d", i), S_valid, 1'b1);
      chk($sformatf("cont_grant_%0d", i), Grant,   exp_g[i]);
      chk($sformatf("cont_sel_%0d", i),   Sel,     exp_g[i][1]);
    end

    B_data = 16'hBEEF; B_last = 1'b1;
    tick();
    chk("early_data",  S_data,  16'hBEEF);
    chk("early_grant", Grant,   2'b01);
    chk("early_cnt",   dbg_cnt, 3'd0);
    B_valid = 1'b0; B_last = 1'b0;
    tick();
    chk("early_next_a", S_data,  16'hA008);
    chk("early_cnt1",   dbg_cnt, 3'd1);

    S_ready = 1'b0;
    #1;
    chk("bp_a_ready_0", A_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_data_%0d", i),  S_data,  16'hA008);
      chk($sformatf("bp_valid_%0d", i), S_valid, 1'b1);
      chk($sformatf("bp_ready_%0d", i), A_ready, 1'b0);
    end
    S_ready = 1'b1;
    tick();
    chk("bp_resume_data", S_data,  16'hA009);
    chk("bp_resume_cnt",  dbg_cnt, 3'd2);
    A_valid = 1'b0;
    tick();
    chk("hold_s_valid", S_valid, 1'b0);
    chk("hold_grant",   Grant,   2'b01);
    chk("hold_cnt",     dbg_cnt, 3'd2);

    rst = 1'b1; A_valid = 1'b1;
    tick();
    chk("midrst_grant",   Grant,   2'b00);
    chk("midrst_s_valid", S_valid, 1'b0);
    chk("midrst_s_data",  S_data,  16'h0000);
    chk("midrst_cnt",     dbg_cnt, 3'd0);
    rst = 1'b0; B_valid = 1'b1;
    tick();
    chk("midrst_regrant_a", Grant,   2'b01);
    chk("midrst_no_word",   S_valid, 1'b0);

    B_valid = 1'b0; auto_data = 1'b0; A_data = 16'h1111;
    tick();
    chk("single_w1",   S_data,  16'h1111);
    chk("single_v1",   S_valid, 1'b1);
    chk("single_cnt1", dbg_cnt, 3'd1);
    A_data = 16'h2222;
    tick();
    chk("single_w2", S_data, 16'h2222);
    chk("single_g2", Grant,  2'b01);
    A_data = 16'h3333; A_last = 1'b1;
    tick();
    chk("single_w3",    S_data,  16'h3333);
    chk("single_v3",    S_valid, 1'b1);
    chk("single_idle",  Grant,   2'b00);
    chk("single_cnt0",  dbg_cnt, 3'd0);
    A_valid = 1'b0; A_last = 1'b0;
    tick();
    chk("single_drain", S_valid, 1'b0);
    chk("single_g_end", Grant,   2'b00);
    chk("single_sel",   Sel,     1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
